// File: rtl/ball_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ball_pkg                                               |
// | Description : Shared direction encoding and USB HID keycodes for    |
// |               the ball motion controller.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ball_pkg;

  // Direction state of the ball; encodings are visible on the dir port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  // USB HID usage IDs for the keys that steer the ball.
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage : ball_pkg
`default_nettype wire

// File: rtl/vsync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vsync_edge                                             |
// | Description : Registers the active-low vertical sync and produces a  |
// |               one-cycle tick on its falling edge (start of frame).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  // Delay vs by one cycle; resetting to 0 means a vs already low at
  // reset release cannot look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs;
    end
  end

  assign tick = vs_q & ~vs;

endmodule : vsync_edge
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ball_motion                                            |
// | Description : Frame-rate ball position controller. On every vsync    |
// |               falling edge it decodes the HID keycode into a         |
// |               direction, reflects it at the screen edges and steps   |
// |               the ball centre by STEP pixels.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ball_motion
  import ball_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE     = 4,
  parameter int STEP     = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic       vs,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [2:0] dir,
  output logic       frame_tick
);

  // Edge limits as 11-bit unsigned so sums never overflow.
  localparam logic [10:0] MARGIN = 11'(SIZE + STEP);
  localparam logic [10:0] X_HI   = 11'(X_MAX);
  localparam logic [10:0] Y_HI   = 11'(Y_MAX);
  localparam logic [10:0] X_LO   = 11'(X_MIN + SIZE + STEP);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN + SIZE + STEP);
  localparam logic [9:0]  STEP_W = 10'(STEP);

  logic       tick;
  dir_t       state;
  dir_t       next_state;
  dir_t       decoded;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [10:0] x_ext;
  logic [10:0] y_ext;

  vsync_edge u_vsync_edge (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .vs    (vs),
    .tick  (tick)
  );

  assign x_ext = {1'b0, ball_x};
  assign y_ext = {1'b0, ball_y};

  // Direction state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next direction: key decode then edge reflection, only on a frame tick;
  // also derives the stepped position from the final direction.
  always_comb begin
    decoded    = state;
    next_state = state;
    next_x     = ball_x;
    next_y     = ball_y;
    if (tick) begin
      case (keycode)
        KEY_W:     decoded = UP;
        KEY_S:     decoded = DOWN;
        KEY_A:     decoded = LEFT;
        KEY_D:     decoded = RIGHT;
        KEY_SPACE: decoded = IDLE;
        default:   decoded = state;
      endcase

      next_state = decoded;
      case (decoded)
        RIGHT:   if (x_ext + MARGIN > X_HI) next_state = LEFT;
        LEFT:    if (x_ext < X_LO)          next_state = RIGHT;
        DOWN:    if (y_ext + MARGIN > Y_HI) next_state = UP;
        UP:      if (y_ext < Y_LO)          next_state = DOWN;
        default: next_state = decoded;
      endcase

      case (next_state)
        RIGHT:   next_x = ball_x + STEP_W;
        LEFT:    next_x = ball_x - STEP_W;
        DOWN:    next_y = ball_y + STEP_W;
        UP:      next_y = ball_y - STEP_W;
        default: begin
          next_x = ball_x;
          next_y = ball_y;
        end
      endcase
    end
  end

  // Position registers and the frame pulse; position only moves on a tick.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ball_x     <= 10'(X_CENTER);
      ball_y     <= 10'(Y_CENTER);
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (tick) begin
        ball_x <= next_x;
        ball_y <= next_y;
      end
    end
  end

  assign dir = state;

endmodule : ball_motion
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ball_motion                                         |
// | Description : Self-checking bench for ball_motion with an integer    |
// |               reference model and randomized frames.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ball_motion;

  logic       clk;
  logic       rst_n;
  logic [7:0] keycode;
  logic       vs;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [2:0] dir;
  logic       frame_tick;

  int checks;
  int fails;
  int tick_count;

  // Reference model state (plain integers)
  int mx, my, md;
  bit mvsq, mtick;

  ball_motion dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .keycode       (keycode),
    .vs            (vs),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .dir           (dir),
    .frame_tick    (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: on a vsync falling edge, pick the direction from the
  // key (or keep it), bounce it off the wall it would cross, then step.
  always @(posedge clk or negedge rst_n) begin
    int d;
    if (!rst_n) begin
      mx = 320; my = 240; md = 0; mvsq = 0; mtick = 0;
    end else begin
      mtick = mvsq && !vs;
      mvsq  = vs;
      if (mtick) begin
        d = md;
        case (keycode)
          8'h1A: d = 1;
          8'h16: d = 2;
          8'h04: d = 3;
          8'h07: d = 4;
          8'h2C: d = 0;
          default: d = md;
        endcase
        if      (d == 4 && mx + 4 + 1 > 639) d = 3;
        else if (d == 3 && mx < 0 + 4 + 1)   d = 4;
        else if (d == 2 && my + 4 + 1 > 479) d = 1;
        else if (d == 1 && my < 0 + 4 + 1)   d = 2;
        md = d;
        if (d == 1) my = my - 1;
        if (d == 2) my = my + 1;
        if (d == 3) mx = mx - 1;
        if (d == 4) mx = mx + 1;
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("ball_x", int'(ball_x), mx);
    check("ball_y", int'(ball_y), my);
    check("dir", int'(dir), md);
    check("frame_tick", int'(frame_tick), int'(mtick));
    if (frame_tick) tick_count++;
  end

  // One frame: vs high for hi cycles, then falls with keycode k applied in
  // that same cycle, then stays low for lo cycles. Called at a negedge.
  task automatic frame(input logic [7:0] k, input int hi, input int lo, input bit junk);
    vs = 1'b1;
    for (int i = 0; i < hi; i++) begin
      if (junk) keycode = 8'($urandom);
      @(negedge clk);
    end
    keycode = k;
    vs = 1'b0;
    @(negedge clk);
    for (int i = 0; i < lo; i++) begin
      if (junk) keycode = 8'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    int sx;
    int tc0;
    logic [7:0] keys [7];
    keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h00, 8'h55};
    checks = 0; fails = 0; tick_count = 0;
    rst_n = 1'b0; vs = 1'b0; keycode = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_x", int'(ball_x), 320);
    check("reset_y", int'(ball_y), 240);
    check("reset_dir", int'(dir), 0);
    check("reset_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_tick_after_release", tick_count, 0);

    // Idle frames
    for (int i = 0; i < 3; i++) frame(8'h00, 3, 4, 1'b0);
    check("idle_ticks", tick_count, 3);
    check("idle_x", int'(ball_x), 320);
    check("idle_dir", int'(dir), 0);

    // Right motion then hold
    frame(8'h07, 2, 2, 1'b0);
    for (int i = 0; i < 9; i++) frame(8'h00, 2, 2, 1'b0);
    check("right_x", int'(ball_x), 330);
    check("right_y", int'(ball_y), 240);
    check("right_dir", int'(dir), 4);

    // Right edge
    for (int i = 0; i < 400 && mx != 635; i++) frame(8'h07, 1, 1, 1'b0);
    check("edge_reach_x", int'(ball_x), 635);
    frame(8'h07, 1, 1, 1'b0);
    check("right_reflect_dir", int'(dir), 3);
    check("right_reflect_x", int'(ball_x), 634);

    // Top edge
    for (int i = 0; i < 400 && my != 4; i++) frame(8'h1A, 1, 1, 1'b0);
    check("top_reach_y", int'(ball_y), 4);
    frame(8'h1A, 1, 1, 1'b0);
    check("top_reflect_dir", int'(dir), 2);
    check("top_reflect_y", int'(ball_y), 5);

    // Same-cycle key change, then a late change ignored
    sx = int'(ball_x);
    vs = 1'b1; keycode = 8'h07;
    repeat (2) @(negedge clk);
    keycode = 8'h04; vs = 1'b0;
    @(negedge clk);
    check("samecycle_dir", int'(dir), 3);
    check("samecycle_x", int'(ball_x), sx - 1);
    @(negedge clk);
    keycode = 8'h07;
    repeat (3) @(negedge clk);
    check("late_key_dir", int'(dir), 3);
    check("late_key_x", int'(ball_x), sx - 1);

    // Move to x=400 then reset mid-frame with vs low
    for (int i = 0; i < 400 && mx != 400; i++) frame(8'h04, 1, 1, 1'b0);
    check("pre_reset_x", int'(ball_x), 400);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_x", int'(ball_x), 320);
    check("async_reset_dir", int'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tc0 = tick_count;
    repeat (5) @(negedge clk);
    check("post_reset_no_tick", tick_count, tc0);
    frame(8'h00, 2, 2, 1'b0);
    check("post_reset_one_tick", tick_count, tc0 + 1);

    // Randomized frames, including back-to-back and junk keys between ticks
    for (int i = 0; i < 400; i++) begin
      frame(keys[$urandom_range(0, 6)], $urandom_range(1, 4),
            $urandom_range(0, 4), 1'b1);
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_ball_motion
`default_nettype wire
